// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal entry / display paths.
// SEG7_INPUT_EN selects a 7-bit active-low segment input instead of plain BCD.
package bcd_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Active-low abcdefg patterns, shared with the display encoders
   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;

`ifdef SEG7_INPUT_EN
   localparam int DIGIT_W = 7;
`else
   localparam int DIGIT_W = 4;
`endif

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern into a BCD digit.
// Patterns outside 0..9 raise invalid and return digit 0.
module seg7_to_bcd
   import bcd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       invalid
);

   always_comb begin
      digit   = 4'd0;
      invalid = 1'b0;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/bcd_entry_decoder.sv
// Serial decimal digit entry (MSD first) accumulated into an unsigned binary value.
// Build option SEG7_INPUT_EN: digitIn is a 7-segment pattern decoded by seg7_to_bcd.
//
// state   | meaning
// COLLECT | accepting digits, waiting for enter
// HOLD    | binOut presented, waiting for binReady
module bcd_entry_decoder
   import bcd_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MAX_DIGITS = 3,
   localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               digitValid,
   input  logic [DIGIT_W-1:0] digitIn,
   output logic               digitReady,
   input  logic               clearIn,
   input  logic               enterIn,
   output logic [WIDTH-1:0]   binOut,
   output logic               binValid,
   input  logic               binReady,
   output logic               overflow,
   output logic               errDigit,
   output logic [CNT_W-1:0]   digitCount
);

   localparam logic [0:0] ST_COLLECT = COLLECT;
   localparam logic [0:0] ST_HOLD    = HOLD;

   logic [0:0]       state;
   logic [WIDTH+3:0] acc;
   logic [3:0]       dig;
   logic             dig_bad;

`ifdef SEG7_INPUT_EN
   seg7_to_bcd u_seg7_to_bcd (
      .seg     (digitIn),
      .digit   (dig),
      .invalid (dig_bad)
   );
`else
   assign dig     = digitIn;
   assign dig_bad = (digitIn > 4'd9);
`endif

   logic [WIDTH+7:0] acc_ext;
   logic [WIDTH+7:0] sum;
   logic             ovf_hit;
   logic             cnt_full;
   logic             dig_take;
   logic             dig_ok;
   logic             dig_rej;
   logic             ovf_next;
   logic [WIDTH+3:0] acc_upd;
   logic [CNT_W-1:0] cnt_upd;
   logic             commit;

   // Extra headroom so acc*10 never wraps before the overflow compare
   assign acc_ext  = (WIDTH+8)'(acc);
   assign sum      = (acc_ext << 3) + (acc_ext << 1) + (WIDTH+8)'(dig);
   assign ovf_hit  = |sum[WIDTH+7:WIDTH];
   assign cnt_full = (digitCount == CNT_W'(MAX_DIGITS));

   assign dig_take = digitValid && (state == ST_COLLECT);
   assign dig_ok   = dig_take && !dig_bad && !cnt_full;
   assign dig_rej  = dig_take && !dig_ok;
   assign ovf_next = overflow | (dig_ok & ovf_hit);
   assign acc_upd  = dig_ok ? sum[WIDTH+3:0] : acc;
   assign cnt_upd  = dig_ok ? digitCount + CNT_W'(1) : digitCount;
   assign commit   = enterIn && (state == ST_COLLECT) && (cnt_upd != '0);

   assign digitReady = (state == ST_COLLECT);
   assign binValid   = (state == ST_HOLD);

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= ST_COLLECT;
         acc        <= '0;
         digitCount <= '0;
         overflow   <= 1'b0;
         binOut     <= '0;
         errDigit   <= 1'b0;
      end else begin
         errDigit <= 1'b0;
         if (clearIn) begin
            state      <= ST_COLLECT;
            acc        <= '0;
            digitCount <= '0;
            overflow   <= 1'b0;
         end else if (state == ST_COLLECT) begin
            errDigit   <= dig_rej;
            acc        <= acc_upd;
            digitCount <= cnt_upd;
            overflow   <= ovf_next;
            if (commit) begin
               state  <= ST_HOLD;
               binOut <= ovf_next ? '1 : acc_upd[WIDTH-1:0];
            end
         end else if (binReady) begin
            state      <= ST_COLLECT;
            acc        <= '0;
            digitCount <= '0;
            overflow   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_entry_decoder.sv
// Scoreboard bench for bcd_entry_decoder; runs in either SEG7_INPUT_EN build.
module tb_bcd_entry_decoder;
   import bcd_pkg::*;

   logic               clk = 1'b0;
   logic               rstN;
   logic               digitValid;
   logic [DIGIT_W-1:0] digitIn;
   logic               digitReady;
   logic               clearIn;
   logic               enterIn;
   logic [7:0]         binOut;
   logic               binValid;
   logic               binReady;
   logic               overflow;
   logic               errDigit;
   logic [1:0]         digitCount;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int val;
      int ovf;
   } exp_t;
   exp_t sb[$];

   bcd_entry_decoder #(.WIDTH(8), .MAX_DIGITS(3)) dut (
      .clk        (clk),
      .rstN       (rstN),
      .digitValid (digitValid),
      .digitIn    (digitIn),
      .digitReady (digitReady),
      .clearIn    (clearIn),
      .enterIn    (enterIn),
      .binOut     (binOut),
      .binValid   (binValid),
      .binReady   (binReady),
      .overflow   (overflow),
      .errDigit   (errDigit),
      .digitCount (digitCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DIGIT_W-1:0] enc(input int d);
`ifdef SEG7_INPUT_EN
      case (d)
         0: return SEG_0;
         1: return SEG_1;
         2: return SEG_2;
         3: return SEG_3;
         4: return SEG_4;
         5: return SEG_5;
         6: return SEG_6;
         7: return SEG_7;
         8: return SEG_8;
         9: return SEG_9;
         default: return 7'b1111111;
      endcase
`else
      return DIGIT_W'(d);
`endif
   endfunction

   // Monitor: every new output presentation is compared against the scoreboard
   logic bv_prev = 1'b0;
   always @(negedge clk) begin
      if (binValid && !bv_prev) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("binOut", int'(binOut), e.val);
            check("overflow_at_out", int'(overflow), e.ovf);
         end
      end
      bv_prev <= binValid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input int d);
      digitValid = 1'b1;
      digitIn    = enc(d);
      tick();
      digitValid = 1'b0;
   endtask

   task automatic enter_expect(input int val, input int ovf);
      sb.push_back('{val, ovf});
      enterIn = 1'b1;
      tick();
      enterIn = 1'b0;
      check("enter_latency_binValid", int'(binValid), 1);
   endtask

   task automatic accept();
      binReady = 1'b1;
      tick();
      binReady = 1'b0;
      check("post_accept_binValid", int'(binValid), 0);
      check("post_accept_count", int'(digitCount), 0);
   endtask

   initial begin
      rstN = 1'b0; digitValid = 1'b0; digitIn = '0;
      clearIn = 1'b0; enterIn = 1'b0; binReady = 1'b0;
      #1;
      check("rst_binValid", int'(binValid), 0);
      check("rst_digitReady", int'(digitReady), 1);
      check("rst_count", int'(digitCount), 0);
      check("rst_binOut", int'(binOut), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_errDigit", int'(errDigit), 0);
      #13 rstN = 1'b1;
      tick();

      // 1: 123
      send_digit(1); send_digit(2); send_digit(3);
      check("count_123", int'(digitCount), 3);
      enter_expect(123, 0);
      @(negedge clk); #1;
      accept();

      // 2: 256 overflows, 255 does not
      send_digit(2); send_digit(5); send_digit(6);
      check("ovf_256", int'(overflow), 1);
      enter_expect(255, 1);
      @(negedge clk); #1;
      accept();
      check("ovf_cleared", int'(overflow), 0);
      send_digit(2); send_digit(5); send_digit(5);
      check("ovf_255", int'(overflow), 0);
      enter_expect(255, 0);
      @(negedge clk); #1;
      accept();

      // 3: invalid digit and digit-count limit
      send_digit(10);
      check("err_invalid", int'(errDigit), 1);
      check("count_invalid", int'(digitCount), 0);
      tick();
      check("err_one_cycle", int'(errDigit), 0);
      enterIn = 1'b1; tick(); enterIn = 1'b0;
      check("enter_empty_ignored", int'(binValid), 0);
      send_digit(9); send_digit(9); send_digit(9);
      check("err_valid_digit", int'(errDigit), 0);
      send_digit(1);
      check("err_4th_digit", int'(errDigit), 1);
      check("count_max", int'(digitCount), 3);
      enter_expect(255, 1);
      @(negedge clk); #1;
      accept();

      // 4: hold stability while digits are driven
      send_digit(4);
      digitValid = 1'b1; digitIn = enc(2);
      enter_expect(42, 0);
      digitIn = enc(7);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_binOut", int'(binOut), 42);
         check("hold_binValid", int'(binValid), 1);
         check("hold_digitReady", int'(digitReady), 0);
         check("hold_count", int'(digitCount), 2);
      end
      digitValid = 1'b0;
      accept();

      // 5: clear beats a concurrent digit, then reset during HOLD
      send_digit(5);
      clearIn = 1'b1; digitValid = 1'b1; digitIn = enc(7);
      tick();
      clearIn = 1'b0; digitValid = 1'b0;
      check("clear_count", int'(digitCount), 0);
      send_digit(3);
      enter_expect(3, 0);
      @(negedge clk); #1;
      accept();
      send_digit(2); send_digit(9);
      enter_expect(29, 0);
      @(negedge clk); #2;
      rstN = 1'b0;
      #1;
      check("async_rst_binValid", int'(binValid), 0);
      check("async_rst_binOut", int'(binOut), 0);
      check("async_rst_digitReady", int'(digitReady), 1);
      #4 rstN = 1'b1;
      tick();

      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_entry_decoder.md
Name: bcd_entry_decoder

Overview:
Decimal digit-entry decoder: the inverse of the binary-to-decimal 7-segment display path. Accepts decimal digits serially, most-significant digit first, e.g. from keypad scan or switch input. Accumulates them into an unsigned binary value and presents the result on a valid/ready output handshake. Sits between the operator input logic and the CPU data/register-load path.

Parameters:
WIDTH, 8, width of the binary result.
MAX_DIGITS, 3, maximum decimal digits accepted per entry.

Ports:
clk  input  1  system clock, rising edge.
rstN  input  1  asynchronous active-low reset.
digitValid  input  1  digit present on digitIn.
digitIn  input  DIGIT_W  4-bit BCD digit; 7 bits when SEG7_INPUT_EN is defined.
digitReady  output  1  block can accept a digit.
clearIn  input  1  discard the entry in progress.
enterIn  input  1  commit the entry.
binOut  output  WIDTH  committed binary value.
binValid  output  1  binOut is valid.
binReady  input  1  consumer accepts binOut.
overflow  output  1  sticky flag: the entry exceeds 2^WIDTH-1.
errDigit  output  1  one-cycle pulse when a digit is rejected.
digitCount  output  clog2(MAX_DIGITS+1)  number of digits accepted so far.

Behaviour:
- Reset (asynchronous, rstN=0): state COLLECT, accumulator=0, binOut=0, binValid=0, overflow=0, errDigit=0, digitCount=0, digitReady=1.
- States: COLLECT (digitReady=1, binValid=0) and HOLD (digitReady=0, binValid=1).
- Accumulator width is WIDTH+4. Update rule: acc_next = acc*10 + d, implemented as (acc<<3)+(acc<<1)+d in a single cycle.
- In COLLECT, a digit is accepted on digitValid && digitReady at the clock edge.
- Digit value >9: rejected, errDigit=1 for one cycle, accumulator and count unchanged.
- digitCount==MAX_DIGITS: any further digit is rejected with an errDigit pulse.
- Valid digit: accumulator updated, digitCount incremented. Leading zeros count as digits.
- overflow is set sticky when acc_next > 2^WIDTH-1. Once set, accumulation continues but has no effect on the result.
- enterIn in COLLECT with digitCount==0: ignored, no output produced.
- enterIn in COLLECT with digitCount>0: next cycle state=HOLD, binValid=1, binOut = overflow ? all-ones : acc[WIDTH-1:0]. Latency from enter to binValid is 1 cycle.
- Digit and enterIn in the same cycle: the digit is accumulated first and is included in binOut. A rejected digit is excluded, and enter proceeds if digitCount>0.
- In HOLD, binOut and binValid stay stable until binReady=1 is sampled. On the following cycle: binValid=0, accumulator=0, digitCount=0, overflow=0, state=COLLECT.
- clearIn has highest priority in either state. Next cycle: accumulator=0, digitCount=0, overflow=0, binValid=0, state=COLLECT. A concurrent digit or enterIn is discarded.
- binOut retains its last value after the handshake and is not cleared.
- Reset asserted mid-entry or mid-HOLD: all outputs return to reset values immediately, with no clock required.

Optional Feature:
SEG7_INPUT_EN
- Defined: DIGIT_W=7. digitIn carries an active-low abcdefg segment pattern, decoded to BCD before accumulation:
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  Any other pattern is treated as an invalid digit (errDigit pulse).
- Undefined: DIGIT_W=4 and digitIn is plain BCD.

Decomposition:
- Shared package bcd_pkg contains:
  - state enum typedef (COLLECT, HOLD);
  - SEG_0..SEG_9 pattern constants, also shared by the display encoders;
  - DIGIT_W localparam selected by the macro.
- One combinational sub-module, seg7_to_bcd: a 7-bit pattern in, a 4-bit digit and an invalid flag out. It is instantiated only under SEG7_INPUT_EN.

Test Plan:
1. Digits 1,2,3 then enterIn → binValid rises 1 cycle later, binOut=123 (8'h7B), overflow=0. With binReady=1, binValid=0 and digitCount=0 the next cycle.
2. Digits 2,5,6 then enterIn → overflow=1, binOut=255. Digits 2,5,5 → overflow=0, binOut=255.
3. digitIn=4'hA → errDigit pulses for 1 cycle, digitCount unchanged. Digits 9,9,9,1 → 4th digit rejected with errDigit, digitCount stays 3.
4. Commit 42, hold binReady=0 for 5 cycles while driving digits → binOut=42 stable, digitReady=0, digits ignored. binReady=1 → binValid drops next cycle.
5. clearIn with digit 7 in the same cycle after entering 5 → count=0, accumulator=0. rstN low during HOLD → binValid=0 and binOut=0 immediately.
6. With SEG7_INPUT_EN: patterns 0010010, 0000100, then enterIn → binOut=29. Pattern 1111111 → errDigit pulse, no count change.
